// File: rtl/ram_2r1w_dp_init.sv
// Two-read / one-write synchronous RAM on a single clock.
// After reset, a sweep writes INIT_VAL to every word while BUSY is high.
// Each read port has its own enable and valid flag, with a latency of 1 or 2 cycles.
// A read that hits the word being written in the same cycle can forward the new data.
module ram_2r1w_dp_init #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                OUT_REG  = 0,
  parameter int                BYPASS   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              SRST_N,
  input  logic              A_EN,
  input  logic [ADDR_W-1:0] A_ADDR,
  output logic [DATA_W-1:0] A_DOUT,
  output logic              A_VALID,
  input  logic              B_EN,
  input  logic [ADDR_W-1:0] B_ADDR,
  output logic [DATA_W-1:0] B_DOUT,
  output logic              B_VALID,
  input  logic              C_WEN,
  input  logic [ADDR_W-1:0] C_ADDR,
  input  logic [DATA_W-1:0] C_DIN,
  output logic              BUSY,
  output logic              C_DROP
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy;
  logic              drop;

  logic              rd_en   [2];
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_dout [2];
  logic              rd_valid[2];

  assign busy   = (state == INIT);
  assign BUSY   = busy;
  assign C_DROP = drop;

  // State register: reset always restarts the init sweep
  always_ff @(posedge CLK) begin
    if (!SRST_N) state <= INIT;
    else         state <= state_nxt;
  end

  // Next state: leave INIT once the last address has been swept; RUN holds until reset
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (&cnt) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Sweep address counter; it only advances during INIT, so it wraps exactly once, on entry to RUN
  always_ff @(posedge CLK) begin
    if (!SRST_N)   cnt <= '0;
    else if (busy) cnt <= cnt + ADDR_W'(1);
  end

  // Storage: the sweep owns the write port during INIT, the user write port owns it in RUN
  always_ff @(posedge CLK) begin
    if (SRST_N) begin
      if (busy)       mem[cnt]    <= INIT_VAL;
      else if (C_WEN) mem[C_ADDR] <= C_DIN;
    end
  end

  // Flag a write that arrives while the sweep is running, one cycle later
  always_ff @(posedge CLK) begin
    if (!SRST_N) drop <= 1'b0;
    else         drop <= busy && C_WEN;
  end

  // Collect both read ports into arrays so that one generate loop can build them
  always_comb begin
    rd_en[0]   = A_EN;
    rd_en[1]   = B_EN;
    rd_addr[0] = A_ADDR;
    rd_addr[1] = B_ADDR;
  end

  assign A_DOUT  = rd_dout[0];
  assign A_VALID = rd_valid[0];
  assign B_DOUT  = rd_dout[1];
  assign B_VALID = rd_valid[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              accept;
    logic              hit;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    assign accept = rd_en[p] && !busy;
    assign hit    = (BYPASS != 0) && C_WEN && (C_ADDR == rd_addr[p]);
    assign word   = hit ? C_DIN : mem[rd_addr[p]];

    // First read stage: capture the word on an accepted read; otherwise hold the data and drop valid
    always_ff @(posedge CLK) begin
      if (!SRST_N) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= accept;
        if (accept) s1_data <= word;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] s2_data;
      logic              s2_valid;

      // Optional output stage: delay the result by one cycle, holding the data between reads
      always_ff @(posedge CLK) begin
        if (!SRST_N) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_dout[p]  = s2_data;
      assign rd_valid[p] = s2_valid;
    end else begin : g_direct
      assign rd_dout[p]  = s1_data;
      assign rd_valid[p] = s1_valid;
    end
  end

endmodule

// File: tb/tb_ram_2r1w_dp_init.sv
// Self-checking bench for ram_2r1w_dp_init.
// Two instances share the clock: a default 64x8 one (latency 1, bypass on) and a
// 256x18 one (latency 2, bypass off, non-zero INIT_VAL). Each has a behavioural model.
module tb_ram_2r1w_dp_init;

  localparam int          OUT_REG0 = 0;
  localparam int          BYPASS0  = 1;
  localparam int          LAT0     = (OUT_REG0 != 0) ? 2 : 1;
  localparam logic [17:0] W_INIT   = 18'h15A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       srst_n, a_en, b_en, c_wen;
  logic [5:0] a_addr, b_addr, c_addr;
  logic [7:0] a_dout, b_dout, c_din;
  logic       a_valid, b_valid, busy, c_drop;

  // wide instance
  logic        w_srst_n, w_a_en, w_b_en, w_c_wen;
  logic [7:0]  w_a_addr, w_b_addr, w_c_addr;
  logic [17:0] w_a_dout, w_b_dout, w_c_din;
  logic        w_a_valid, w_b_valid, w_busy, w_c_drop;

  int n_checks = 0;
  int n_fail   = 0;

  ram_2r1w_dp_init #(
    .DATA_W(8), .ADDR_W(6), .OUT_REG(OUT_REG0), .BYPASS(BYPASS0), .INIT_VAL(8'h00)
  ) dut (
    .CLK(clk), .SRST_N(srst_n),
    .A_EN(a_en), .A_ADDR(a_addr), .A_DOUT(a_dout), .A_VALID(a_valid),
    .B_EN(b_en), .B_ADDR(b_addr), .B_DOUT(b_dout), .B_VALID(b_valid),
    .C_WEN(c_wen), .C_ADDR(c_addr), .C_DIN(c_din),
    .BUSY(busy), .C_DROP(c_drop)
  );

  ram_2r1w_dp_init #(
    .DATA_W(18), .ADDR_W(8), .OUT_REG(1), .BYPASS(0), .INIT_VAL(W_INIT)
  ) dut_w (
    .CLK(clk), .SRST_N(w_srst_n),
    .A_EN(w_a_en), .A_ADDR(w_a_addr), .A_DOUT(w_a_dout), .A_VALID(w_a_valid),
    .B_EN(w_b_en), .B_ADDR(w_b_addr), .B_DOUT(w_b_dout), .B_VALID(w_b_valid),
    .C_WEN(w_c_wen), .C_ADDR(w_c_addr), .C_DIN(w_c_din),
    .BUSY(w_busy), .C_DROP(w_c_drop)
  );

  // ---------------- reference model, default instance ----------------
  logic [7:0] mdl [64];
  int         sweep_left;
  bit         run;
  bit         pend_a_v, pend_b_v;
  logic [7:0] pend_a_d, pend_b_d;
  bit         exp_a_valid, exp_b_valid, exp_busy, exp_drop;
  logic [7:0] exp_a_dout, exp_b_dout;

  // Advance one clock edge with the current inputs and update the expected outputs.
  task automatic step();
    bit         av, bv, va, vb;
    logic [7:0] ad, bd, da, db;
    if (srst_n !== 1'b1) begin
      run = 0;
      sweep_left = 64;
      foreach (mdl[i]) mdl[i] = 8'h00;
      pend_a_v = 0; pend_b_v = 0;
      exp_a_valid = 0; exp_b_valid = 0;
      exp_a_dout = 8'h00; exp_b_dout = 8'h00;
      exp_drop = 0;
    end else begin
      av = run && a_en;
      bv = run && b_en;
      ad = (BYPASS0 != 0 && c_wen && c_addr == a_addr) ? c_din : mdl[a_addr];
      bd = (BYPASS0 != 0 && c_wen && c_addr == b_addr) ? c_din : mdl[b_addr];
      exp_drop = !run && c_wen;
      if (run && c_wen) mdl[c_addr] = c_din;
      if (!run) begin
        sweep_left--;
        if (sweep_left == 0) run = 1;
      end
      if (LAT0 == 1) begin
        va = av; da = ad; vb = bv; db = bd;
      end else begin
        va = pend_a_v; da = pend_a_d; vb = pend_b_v; db = pend_b_d;
        pend_a_v = av; pend_a_d = ad; pend_b_v = bv; pend_b_d = bd;
      end
      exp_a_valid = va;
      if (va) exp_a_dout = da;
      exp_b_valid = vb;
      if (vb) exp_b_dout = db;
    end
    exp_busy = !run;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model, wide instance (latency 2, no bypass) ----------------
  logic [17:0] wmdl [256];
  int          w_sweep_left;
  bit          w_run;
  bit          w_pa_v, w_pb_v;
  logic [17:0] w_pa_d, w_pb_d;
  bit          w_exp_a_valid, w_exp_b_valid, w_exp_busy, w_exp_drop;
  logic [17:0] w_exp_a_dout, w_exp_b_dout;

  task automatic w_step();
    bit          av, bv;
    logic [17:0] ad, bd;
    if (w_srst_n !== 1'b1) begin
      w_run = 0;
      w_sweep_left = 256;
      foreach (wmdl[i]) wmdl[i] = W_INIT;
      w_pa_v = 0; w_pb_v = 0;
      w_exp_a_valid = 0; w_exp_b_valid = 0;
      w_exp_a_dout = '0; w_exp_b_dout = '0;
      w_exp_drop = 0;
    end else begin
      av = w_run && w_a_en;
      bv = w_run && w_b_en;
      ad = wmdl[w_a_addr];
      bd = wmdl[w_b_addr];
      w_exp_drop = !w_run && w_c_wen;
      if (w_run && w_c_wen) wmdl[w_c_addr] = w_c_din;
      if (!w_run) begin
        w_sweep_left--;
        if (w_sweep_left == 0) w_run = 1;
      end
      w_exp_a_valid = w_pa_v;
      if (w_pa_v) w_exp_a_dout = w_pa_d;
      w_exp_b_valid = w_pb_v;
      if (w_pb_v) w_exp_b_dout = w_pb_d;
      w_pa_v = av; w_pa_d = ad; w_pb_v = bv; w_pb_d = bd;
    end
    w_exp_busy = !w_run;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_en = 0; b_en = 0; c_wen = 0;
    a_addr = '0; b_addr = '0; c_addr = '0; c_din = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int busy_cycles;
    idle_inputs();
    srst_n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({a_valid, a_dout, b_valid, b_dout, busy, c_drop} !== {1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL reset_values: got %h required %h",
                 {a_valid, a_dout, b_valid, b_dout, busy, c_drop}, {1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
      end
    end
    srst_n = 1;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      step();
    end
    n_checks++;
    if (busy_cycles !== 64) begin
      n_fail++;
      $display("[TB] FAIL sweep_length: got %0d busy cycles required 64", busy_cycles);
    end
    for (int i = 0; i < 64; i++) begin
      a_en = 1; a_addr = 6'(i);
      b_en = 1; b_addr = 6'(63 - i);
      step();
      if (LAT0 == 2 && i == 63) begin
        a_en = 0; b_en = 0;
        step();
      end
      n_checks++;
      if ({a_valid, a_dout, b_valid, b_dout} !== {1'b1, 8'h00, 1'b1, 8'h00}) begin
        n_fail++;
        $display("[TB] FAIL init_readback[%0d]: got %h required %h",
                 i, {a_valid, a_dout, b_valid, b_dout}, {1'b1, 8'h00, 1'b1, 8'h00});
      end
    end
    idle_inputs();
    step();
    n_checks++;
    if ({a_valid, b_valid} !== {exp_a_valid, exp_b_valid}) begin
      n_fail++;
      $display("[TB] FAIL valid_drop: got %b required %b", {a_valid, b_valid}, {exp_a_valid, exp_b_valid});
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    c_wen = 1; c_addr = 6'h11; c_din = 8'hA5;
    step();
    c_addr = 6'h3F; c_din = 8'h3C;
    step();
    c_wen = 0;
    a_en = 1; a_addr = 6'h11;
    b_en = 1; b_addr = 6'h3F;
    step();
    a_en = 0; b_en = 0;
    if (LAT0 == 2) step();
    n_checks++;
    if ({a_valid, a_dout, b_valid, b_dout} !== {1'b1, 8'hA5, 1'b1, 8'h3C}) begin
      n_fail++;
      $display("[TB] FAIL write_read: got %h required %h",
               {a_valid, a_dout, b_valid, b_dout}, {1'b1, 8'hA5, 1'b1, 8'h3C});
    end
    step();
    n_checks++;
    if ({a_valid, a_dout, b_valid, b_dout} !== {1'b0, 8'hA5, 1'b0, 8'h3C}) begin
      n_fail++;
      $display("[TB] FAIL dout_hold: got %h required %h",
               {a_valid, a_dout, b_valid, b_dout}, {1'b0, 8'hA5, 1'b0, 8'h3C});
    end
  endtask

  task automatic test_collision();
    logic [7:0] want;
    idle_inputs();
    c_wen = 1; c_addr = 6'h05; c_din = 8'h11;
    step();
    c_din = 8'h77;
    a_en = 1; a_addr = 6'h05;
    b_en = 1; b_addr = 6'h05;
    step();
    c_wen = 0; a_en = 0; b_en = 0;
    if (LAT0 == 2) step();
    want = (BYPASS0 != 0) ? 8'h77 : 8'h11;
    n_checks++;
    if ({a_valid, a_dout, b_valid, b_dout} !== {1'b1, want, 1'b1, want}) begin
      n_fail++;
      $display("[TB] FAIL collision: got %h required %h",
               {a_valid, a_dout, b_valid, b_dout}, {1'b1, want, 1'b1, want});
    end
    a_en = 1; a_addr = 6'h05;
    step();
    a_en = 0;
    if (LAT0 == 2) step();
    n_checks++;
    if ({a_valid, a_dout} !== {1'b1, 8'h77}) begin
      n_fail++;
      $display("[TB] FAIL collision_after: got %h required %h", {a_valid, a_dout}, {1'b1, 8'h77});
    end
  endtask

  task automatic test_dropped_write();
    int guard;
    idle_inputs();
    srst_n = 0;
    step();
    srst_n = 1;
    repeat (10) step();
    c_wen = 1; c_addr = 6'h02; c_din = 8'hFF;
    step();
    c_wen = 0;
    n_checks++;
    if (c_drop !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drop_pulse: got %b required 1", c_drop);
    end
    step();
    n_checks++;
    if (c_drop !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_clear: got %b required 0", c_drop);
    end
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      guard++;
      step();
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_sweep_end: BUSY got %b required 0 within bound", busy);
    end
    a_en = 1; a_addr = 6'h02;
    step();
    a_en = 0;
    if (LAT0 == 2) step();
    n_checks++;
    if ({a_valid, a_dout} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("[TB] FAIL dropped_word: got %h required %h", {a_valid, a_dout}, {1'b1, 8'h00});
    end
  endtask

  task automatic test_reset_mid();
    int busy_cycles;
    bit saw_valid;
    idle_inputs();
    c_wen = 1; c_addr = 6'h20; c_din = 8'h5A;
    step();
    c_wen = 0;
    a_en = 1;
    for (int i = 0; i < 6; i++) begin
      a_addr = 6'(6'h1E + i);
      step();
      n_checks++;
      if ({a_valid, a_dout} !== {exp_a_valid, exp_a_dout}) begin
        n_fail++;
        $display("[TB] FAIL stream_read[%0d]: got %h required %h", i, {a_valid, a_dout}, {exp_a_valid, exp_a_dout});
      end
    end
    srst_n = 0;
    step();
    n_checks++;
    if ({a_valid, a_dout, busy} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got %h required %h", {a_valid, a_dout, busy}, {1'b0, 8'h00, 1'b1});
    end
    srst_n = 1;
    busy_cycles = 0;
    saw_valid = 0;
    while (busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      a_addr = 6'($urandom_range(0, 63));
      step();
      if (busy === 1'b1 && a_valid !== 1'b0) saw_valid = 1;
    end
    n_checks++;
    if (busy_cycles !== 64) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_sweep: got %0d busy cycles required 64", busy_cycles);
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL valid_during_init: got 1 required 0");
    end
    a_addr = 6'h20;
    step();
    a_en = 0;
    if (LAT0 == 2) step();
    n_checks++;
    if ({a_valid, a_dout} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("[TB] FAIL reinit_word: got %h required %h", {a_valid, a_dout}, {1'b1, 8'h00});
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 500; i++) begin
      srst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      a_en   = 1'($urandom_range(0, 1));
      b_en   = 1'($urandom_range(0, 1));
      c_wen  = 1'($urandom_range(0, 1));
      a_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      b_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      c_addr = 6'($urandom_range(0, 7));
      c_din  = 8'($urandom);
      step();
      n_checks++;
      if ({a_valid, a_dout, b_valid, b_dout, busy, c_drop} !==
          {exp_a_valid, exp_a_dout, exp_b_valid, exp_b_dout, exp_busy, exp_drop}) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: got %h required %h", i,
                 {a_valid, a_dout, b_valid, b_dout, busy, c_drop},
                 {exp_a_valid, exp_a_dout, exp_b_valid, exp_b_dout, exp_busy, exp_drop});
      end
    end
    idle_inputs();
    srst_n = 1;
  endtask

  task automatic test_wide_stream();
    int busy_cycles;
    bit saw_valid;
    w_a_en = 0; w_b_en = 0; w_c_wen = 0;
    w_a_addr = '0; w_b_addr = '0; w_c_addr = '0; w_c_din = '0;
    w_srst_n = 0;
    w_step();
    w_step();
    n_checks++;
    if ({w_a_valid, w_a_dout, w_b_valid, w_b_dout, w_busy} !== {1'b0, 18'h0, 1'b0, 18'h0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL wide_reset: got %h", {w_a_valid, w_a_dout, w_b_valid, w_b_dout, w_busy});
    end
    w_srst_n = 1;
    busy_cycles = 0;
    while (w_busy === 1'b1 && busy_cycles < 600) begin
      busy_cycles++;
      w_step();
    end
    n_checks++;
    if (busy_cycles !== 256) begin
      n_fail++;
      $display("[TB] FAIL wide_sweep_length: got %0d required 256", busy_cycles);
    end
    // write word i while A reads the word written last cycle and B reads the word being written
    for (int i = 0; i < 256; i++) begin
      w_c_wen = 1; w_c_addr = 8'(i);
      w_c_din = (i == 8'h33) ? 18'h2ABCD : 18'($urandom);
      w_a_en = 1; w_a_addr = 8'(i - 1);
      w_b_en = 1; w_b_addr = 8'(i);
      w_step();
      n_checks++;
      if ({w_a_valid, w_a_dout, w_b_valid, w_b_dout, w_busy, w_c_drop} !==
          {w_exp_a_valid, w_exp_a_dout, w_exp_b_valid, w_exp_b_dout, w_exp_busy, w_exp_drop}) begin
        n_fail++;
        $display("[TB] FAIL wide_stream[%0d]: got %h required %h", i,
                 {w_a_valid, w_a_dout, w_b_valid, w_b_dout, w_busy, w_c_drop},
                 {w_exp_a_valid, w_exp_a_dout, w_exp_b_valid, w_exp_b_dout, w_exp_busy, w_exp_drop});
      end
    end
    w_c_wen = 0;
    for (int i = 0; i < 257; i++) begin
      w_a_en = (i < 256); w_a_addr = 8'(i);
      w_b_en = (i < 256); w_b_addr = 8'(255 - i);
      w_step();
      n_checks++;
      if ({w_a_valid, w_a_dout, w_b_valid, w_b_dout} !==
          {w_exp_a_valid, w_exp_a_dout, w_exp_b_valid, w_exp_b_dout}) begin
        n_fail++;
        $display("[TB] FAIL wide_readback[%0d]: got %h required %h", i,
                 {w_a_valid, w_a_dout, w_b_valid, w_b_dout},
                 {w_exp_a_valid, w_exp_a_dout, w_exp_b_valid, w_exp_b_dout});
      end
    end
    w_a_en = 1; w_a_addr = 8'h33;
    w_step();
    w_a_en = 0;
    w_step();
    n_checks++;
    if ({w_a_valid, w_a_dout} !== {1'b1, 18'h2ABCD}) begin
      n_fail++;
      $display("[TB] FAIL wide_value: got %h required %h", {w_a_valid, w_a_dout}, {1'b1, 18'h2ABCD});
    end
    // reset while a read is in the output pipeline
    w_a_en = 1; w_a_addr = 8'h33;
    w_step();
    w_srst_n = 0;
    w_step();
    n_checks++;
    if ({w_a_valid, w_a_dout, w_busy} !== {1'b0, 18'h0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL wide_mid_reset: got %h required %h", {w_a_valid, w_a_dout, w_busy}, {1'b0, 18'h0, 1'b1});
    end
    w_srst_n = 1;
    busy_cycles = 0;
    saw_valid = 0;
    while (w_busy === 1'b1 && busy_cycles < 600) begin
      busy_cycles++;
      w_step();
      if (w_a_valid !== 1'b0) saw_valid = 1;
    end
    n_checks++;
    if (busy_cycles !== 256 || saw_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wide_resweep: got %0d cycles valid_seen=%0b required 256 and 0", busy_cycles, saw_valid);
    end
    w_a_addr = 8'h33;
    w_step();
    w_a_en = 0;
    w_step();
    n_checks++;
    if ({w_a_valid, w_a_dout} !== {1'b1, W_INIT}) begin
      n_fail++;
      $display("[TB] FAIL wide_reinit_word: got %h required %h", {w_a_valid, w_a_dout}, {1'b1, W_INIT});
    end
  endtask

  initial begin
    w_srst_n = 0;
    w_a_en = 0; w_b_en = 0; w_c_wen = 0;
    w_a_addr = '0; w_b_addr = '0; w_c_addr = '0; w_c_din = '0;
    srst_n = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_collision();
    test_dropped_write();
    test_reset_mid();
    test_random();
    test_wide_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
